shift_pla_pipe: RTL and testbench

//  Multi-lane, pipelined shift-only PLA approximation of tanh (and sigmoid via mode bit).

---
 rtl/shift_pla_pkg.sv | 21 ++
 rtl/shift_pla_lane.sv | 129 ++++++++++++
 rtl/shift_pla_pipe.sv | 97 +++++++++
 tb/tb_shift_pla_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pla_pkg.sv
// Shared constants for the shift-only PLA tanh/sigmoid pipeline.
package shift_pla_pkg;

  // Activation selected by the mode bit that travels with each beat.
  localparam logic MODE_TANH    = 1'b0;
  localparam logic MODE_SIGMOID = 1'b1;

  // Register stages between input accept and output: decode, term, combine.
  localparam int STAGES = 3;

  // Unit value in a Q0.out_f output word.
  function automatic int one_of(input int out_f);
    return 1 << out_f;
  endfunction

  // Largest positive output magnitude (ONE - 1).
  function automatic int maxp_of(input int out_f);
    return (1 << out_f) - 1;
  endfunction

endpackage

// File: rtl/shift_pla_lane.sv
// One lane of the PLA datapath: S1 magnitude decode, S2 shifted term, S3 combine.
// All registers advance together on en; no valid tracking lives here.
module shift_pla_lane
  import shift_pla_pkg::*;
#(
  parameter int W_IN  = 16,
  parameter int IN_I  = 4,
  parameter int OUT_F = 14,
  parameter int SAT_K = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              en,
  input  logic              mode,
  input  logic [W_IN-1:0]   x,
  output logic [OUT_F:0]    y,
  output logic              sat
);

  localparam int IN_F = W_IN - IN_I;
  localparam int K_W  = IN_I - 1;
  localparam int T_W  = OUT_F + 1;
  localparam logic [T_W-1:0] ONE_T  = T_W'(one_of(OUT_F));
  localparam logic [T_W-1:0] MAXP_T = T_W'(maxp_of(OUT_F));
  localparam logic [W_IN-1:0] X_MIN = {1'b1, {(W_IN-1){1'b0}}};

  // S1 combinational: |x| with the most-negative input clamped, halved for sigmoid.
  logic [W_IN-2:0] mag;
  logic [W_IN-2:0] mag_m;

  // S1 magnitude and mode pre-scale
  always_comb begin
    mag = x[W_IN-2:0];
    if (x == X_MIN) begin
      mag = '1;
    end else if (x[W_IN-1]) begin
      mag = (W_IN-1)'(-x);
    end
    mag_m = (mode == MODE_SIGMOID) ? (mag >> 1) : mag;
  end

  logic            s1_sign;
  logic            s1_mode;
  logic [K_W-1:0]  s1_k;
  logic [IN_F-1:0] s1_f;

  // S1 register: split magnitude into integer k and fraction f
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_sign <= 1'b0;
      s1_mode <= 1'b0;
      s1_k    <= '0;
      s1_f    <= '0;
    end else if (en) begin
      s1_sign <= x[W_IN-1];
      s1_mode <= mode;
      s1_k    <= mag_m[W_IN-2:IN_F];
      s1_f    <= mag_m[IN_F-1:0];
    end
  end

  // Fraction rescaled to OUT_F bits (truncating when narrowing).
  logic [OUT_F-1:0] fs;
  generate
    if (OUT_F >= IN_F) begin : g_widen
      assign fs = OUT_F'(s1_f) << (OUT_F - IN_F);
    end else begin : g_narrow
      assign fs = OUT_F'(s1_f >> (IN_F - OUT_F));
    end
  endgenerate

  logic [K_W:0]   shift2;
  logic [T_W-1:0] t;
  logic [T_W-1:0] term;

  // S2 combinational: t = ONE - f/2 - f/4, then scaled by 2^-2k
  always_comb begin
    shift2 = {s1_k, 1'b0};
    t      = ONE_T - T_W'(fs >> 1) - T_W'(fs >> 2);
    term   = (int'(shift2) >= T_W) ? '0 : (t >> shift2);
  end

  logic           s2_sign;
  logic           s2_mode;
  logic           s2_sat;
  logic [T_W-1:0] s2_term;

  // S2 register: carry the term plus the saturation decision
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s2_sign <= 1'b0;
      s2_mode <= 1'b0;
      s2_sat  <= 1'b0;
      s2_term <= '0;
    end else if (en) begin
      s2_sign <= s1_sign;
      s2_mode <= s1_mode;
      s2_sat  <= (int'(s1_k) >= SAT_K);
      s2_term <= term;
    end
  end

  logic [T_W-1:0] y_raw;
  logic [T_W-1:0] y_mag;
  logic [T_W-1:0] y_s;
  logic [T_W:0]   sig_sum;
  logic [T_W-1:0] y_out;

  // S3 combinational: clamp below ONE, restore sign, map to sigmoid range if asked
  always_comb begin
    y_raw   = ONE_T - s2_term;
    y_mag   = (s2_sat || (y_raw > MAXP_T)) ? MAXP_T : y_raw;
    y_s     = s2_sign ? -y_mag : y_mag;
    sig_sum = (T_W+1)'(ONE_T) + {y_s[T_W-1], y_s};
    y_out   = (s2_mode == MODE_SIGMOID) ? T_W'(sig_sum >> 1) : y_s;
  end

  // S3 register: the lane's slice of the output beat
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      y   <= '0;
      sat <= 1'b0;
    end else if (en) begin
      y   <= y_out;
      sat <= s2_sat;
    end
  end

endmodule

// File: rtl/shift_pla_pipe.sv
// Multi-lane pipelined shift-only PLA approximation of tanh / sigmoid.
// Optional build macro SHIFT_PLA_STATS_EN adds a saturated-lane counter
// (ports sat_clr, sat_cnt); without it neither port nor counter exists.
//
// Handshake: a beat moves on a rising edge where valid and ready are both
// high; valid must not depend on ready. Internally every stage moves on
// adv = !out_valid | out_ready, and in_ready = adv, so a held output beat
// freezes the whole pipe and out_data/out_sat stay stable until taken.
module shift_pla_pipe
  import shift_pla_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W_IN  = 16,
  parameter int IN_I  = 4,
  parameter int OUT_F = 14,
  parameter int SAT_K = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic [LANES*W_IN-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*(OUT_F+1)-1:0] out_data,
  output logic [LANES-1:0]           out_sat
`ifdef SHIFT_PLA_STATS_EN
  ,
  input  logic                       sat_clr,
  output logic [15:0]                sat_cnt
`endif
);

  localparam int W_OUT = OUT_F + 1;

  logic              adv;
  logic [STAGES-1:0] vld;

  assign adv       = !vld[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[STAGES-1];

  // Valid chain: bubbles ride along as zero bits, shifting only on adv
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld <= '0;
    end else if (adv) begin
      vld <= {vld[STAGES-2:0], in_valid};
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      shift_pla_lane #(
        .W_IN  (W_IN),
        .IN_I  (IN_I),
        .OUT_F (OUT_F),
        .SAT_K (SAT_K)
      ) u_lane (
        .clock  (clock),
        .resetn (resetn),
        .en     (adv),
        .mode   (in_mode),
        .x      (in_data[i*W_IN +: W_IN]),
        .y      (out_data[i*W_OUT +: W_OUT]),
        .sat    (out_sat[i])
      );
    end
  endgenerate

`ifdef SHIFT_PLA_STATS_EN
  logic [15:0] pop;
  logic [16:0] cnt_sum;

  // Number of saturated lanes in the current output beat, added to the count
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + 16'(out_sat[i]);
    end
    cnt_sum = {1'b0, sat_cnt} + {1'b0, pop};
  end

  // Saturation counter: clear beats a same-cycle increment, sticks at all-ones
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      sat_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_shift_pla_pipe.sv
// Bench for shift_pla_pipe: reference vectors, latency/backpressure/reset
// sequences, randomized beats against an integer model of the PLA formula.
module tb_shift_pla_pipe;
  import shift_pla_pkg::*;

  localparam int LANES = 4;
  localparam int W_IN  = 16;
  localparam int W_OUT = 15;
  localparam int BW    = LANES + LANES*W_OUT;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_mode;
  logic [LANES*W_IN-1:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*W_OUT-1:0] out_data;
  logic [LANES-1:0]       out_sat;
`ifdef SHIFT_PLA_STATS_EN
  logic                   sat_clr;
  logic [15:0]            sat_cnt;
`endif

  shift_pla_pipe dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
`ifdef SHIFT_PLA_STATS_EN
    ,
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];
  logic          rand_run = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: y = 1 - 2^-2k (1 - f/2 - f/4) in plain integers, output scale 2^14.
  function automatic logic [15:0] model_lane(input logic mode, input logic [15:0] x);
    int  v, a, k, f, fs, t, term, y, ys, r;
    bit  neg, sat;
    v   = $signed(x);
    neg = (v < 0);
    a   = neg ? -v : v;
    if (a > 32767) a = 32767;
    if (mode == MODE_SIGMOID) a = a / 2;
    k    = a / 4096;
    f    = a % 4096;
    fs   = f * 4;
    t    = 16384 - fs / 2 - fs / 4;
    term = (2 * k >= 15) ? 0 : t / (1 << (2 * k));
    y    = 16384 - term;
    if (y > 16383) y = 16383;
    sat  = (k >= 4);
    if (sat) y = 16383;
    ys   = neg ? -y : y;
    r    = (mode == MODE_SIGMOID) ? (16384 + ys) / 2 : ys;
    return {sat, r[14:0]};
  endfunction

  function automatic logic [BW-1:0] model_beat(input logic mode, input logic [LANES*W_IN-1:0] d);
    logic [LANES-1:0]       s;
    logic [LANES*W_OUT-1:0] y;
    logic [15:0]            r;
    for (int i = 0; i < LANES; i++) begin
      r = model_lane(mode, d[i*W_IN +: W_IN]);
      s[i] = r[15];
      y[i*W_OUT +: W_OUT] = r[14:0];
    end
    return {s, y};
  endfunction

  function automatic logic [15:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'h4000 - 16'($urandom_range(0, 1));
      default: return 16'($urandom());
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic mode, input logic [LANES*W_IN-1:0] data, input logic [BW-1:0] exp);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", n);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("drain_empty", 80'(exp_q.size()), 80'd0);
    @(posedge clock);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          stall_prev = 1'b0;
  logic [BW-1:0] held;

  // Sample on the falling edge; a handshake seen here completes on the next rising edge.
  always @(negedge clock) begin
    if (stall_prev && resetn) begin
      check("stall_hold", {out_valid, out_sat, out_data}, {1'b1, held});
    end
    stall_prev = resetn && out_valid && !out_ready;
    held       = {out_sat, out_data};
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h, required no beat", {out_sat, out_data});
      end else begin
        check("beat", {out_sat, out_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference vectors ----------------
  typedef struct packed {
    logic        mode;
    logic [15:0] x;
    logic [14:0] y;
    logic        sat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANES*W_IN-1:0] d;
    int n;

    vecs[0]  = '{MODE_TANH,    16'h0000, 15'h0000, 1'b0};
    vecs[1]  = '{MODE_TANH,    16'h0800, 15'h1800, 1'b0};
    vecs[2]  = '{MODE_TANH,    16'h1000, 15'h3000, 1'b0};
    vecs[3]  = '{MODE_TANH,    16'hF000, 15'h5000, 1'b0};
    vecs[4]  = '{MODE_TANH,    16'h8000, 15'h4001, 1'b1};
    vecs[5]  = '{MODE_TANH,    16'h5000, 15'h3FFF, 1'b1};
    vecs[6]  = '{MODE_TANH,    16'h3FFF, 15'h3FC0, 1'b0};
    vecs[7]  = '{MODE_TANH,    16'h4000, 15'h3FFF, 1'b1};
    vecs[8]  = '{MODE_TANH,    16'hC000, 15'h4001, 1'b1};
    vecs[9]  = '{MODE_TANH,    16'h7FFF, 15'h3FFF, 1'b1};
    vecs[10] = '{MODE_TANH,    16'hFFFF, 15'h7FFD, 1'b0};
    vecs[11] = '{MODE_TANH,    16'h0FFF, 15'h2FFD, 1'b0};
    vecs[12] = '{MODE_SIGMOID, 16'h0000, 15'h2000, 1'b0};
    vecs[13] = '{MODE_SIGMOID, 16'h2000, 15'h3800, 1'b0};
    vecs[14] = '{MODE_SIGMOID, 16'hE000, 15'h0800, 1'b0};
    vecs[15] = '{MODE_SIGMOID, 16'h8000, 15'h0020, 1'b0};
    vecs[16] = '{MODE_SIGMOID, 16'h7FFF, 15'h3FE0, 1'b0};
    vecs[17] = '{MODE_SIGMOID, 16'h1000, 15'h2C00, 1'b0};

    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef SHIFT_PLA_STATS_EN
    sat_clr   = 1'b0;
`endif

    // Reset state
    #3;
    check("rst_out_valid", 80'(out_valid), 80'd0);
    check("rst_out_data", 80'(out_data), 80'd0);
    check("rst_out_sat", 80'(out_sat), 80'd0);
    check("rst_in_ready", 80'(in_ready), 80'd1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Reference vectors, back to back, same value in every lane
    for (int i = 0; i < NV; i++) begin
      send_beat(vecs[i].mode, {LANES{vecs[i].x}}, {{LANES{vecs[i].sat}}, {LANES{vecs[i].y}}});
    end
    drain();

    // Latency from accept to out_valid on an empty pipe
    d = {16'h0800, 16'hF000, 16'h0000, 16'h5000};
    send_beat(MODE_TANH, d, model_beat(MODE_TANH, d));
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!out_valid && n < 10);
    check("latency", 80'(n), 80'd3);
    drain();

    // Backpressure: 8 beats, out_ready low for cycles 2..5
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic m;
          logic [LANES*W_IN-1:0] bd;
          m = 1'($urandom_range(0, 1));
          for (int j = 0; j < LANES; j++) bd[j*W_IN +: W_IN] = rand_word();
          send_beat(m, bd, model_beat(m, bd));
        end
      end
      begin
        repeat (2) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Randomized beats with random idle gaps and random downstream stalls
    rand_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic m;
          logic [LANES*W_IN-1:0] rd;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
          end
          m = 1'($urandom_range(0, 1));
          for (int j = 0; j < LANES; j++) rd[j*W_IN +: W_IN] = rand_word();
          send_beat(m, rd, model_beat(m, rd));
        end
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          @(posedge clock);
          #1 out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset mid-stream with a full, stalled pipe
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = {rand_word(), rand_word(), rand_word(), rand_word()};
      send_beat(MODE_TANH, d, model_beat(MODE_TANH, d));
    end
    check("prereset_valid", 80'(out_valid), 80'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_valid", 80'(out_valid), 80'd0);
    check("async_rst_data", 80'(out_data), 80'd0);
    check("async_rst_sat", 80'(out_sat), 80'd0);
    exp_q.delete();
    @(negedge clock);
    resetn    = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clock);
    check("dropped_beats", 80'(out_valid), 80'd0);
    @(posedge clock);
    #1;

`ifdef SHIFT_PLA_STATS_EN
    // Saturation counter: clear, count 3 saturated lanes, then clear beats increment
    sat_clr = 1'b1;
    @(posedge clock);
    #1 sat_clr = 1'b0;
    check("sat_cnt_clr", 80'(sat_cnt), 80'd0);
    d = {16'h5000, 16'h8000, 16'h4000, 16'h0000};
    send_beat(MODE_TANH, d, model_beat(MODE_TANH, d));
    drain();
    check("sat_cnt_3", 80'(sat_cnt), 80'd3);
    out_ready = 1'b0;
    send_beat(MODE_TANH, d, model_beat(MODE_TANH, d));
    repeat (2) @(posedge clock);
    #1;
    check("sat_cnt_hold", 80'(sat_cnt), 80'd3);
    sat_clr   = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1 sat_clr = 1'b0;
    check("sat_clr_wins", 80'(sat_cnt), 80'd0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
